asym_bram_fifo_ctrl: RTL

FIFO controller wrapping one asymmetric-width block RAM: narrow write port (WD_W bits, 2^WA_W entries) and wide read port (WD_W*RATIO bits, one wide word packs RATIO consecutive narrow entries). It converts a narrow valid/ready write stream into a wide valid/ready read stream. It owns the pointers, occupancy, BRAM port sequencing and a 2-entry output buffer that hides BRAM read latency. The RAM is external and attached to the memory-side ports.

---
 rtl/asym_fifo_pkg.sv | 26 ++
 rtl/asym_fifo_outbuf.sv | 68 ++++++
 rtl/asym_bram_fifo_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared types and elaboration helpers for the asymmetric BRAM FIFO controller.
package asym_fifo_pkg;

  // Output buffer occupancy; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    BufEmpty = 2'd0,
    BufOne   = 2'd1,
    BufTwo   = 2'd2
  } buf_state_e;

  // log2 of a power-of-two width ratio.
  function automatic int unsigned log2_ratio(input int unsigned ratio);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) == ratio) r = i;
    end
    return r;
  endfunction

  // Wide-word address width derived from the narrow address width.
  function automatic int unsigned ra_width(input int unsigned wa_w, input int unsigned ratio);
    return wa_w - log2_ratio(ratio);
  endfunction

endpackage

// File: rtl/asym_fifo_outbuf.sv
// Two-entry wide skid buffer that catches BRAM read data one cycle after rce.
// The upstream occupancy accounting guarantees no push into a full buffer
// unless a pop happens in the same cycle.
module asym_fifo_outbuf
  import asym_fifo_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] data,
  output logic [1:0]   count
);

  buf_state_e   state_q;
  logic         valid_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;

  // Occupancy FSM with registered valid; head_q is always the oldest word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BufEmpty;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        BufEmpty: begin
          if (push) begin
            head_q  <= push_data;
            state_q <= BufOne;
            valid_q <= 1'b1;
          end
        end
        BufOne: begin
          if (push && pop) begin
            head_q <= push_data;
          end else if (push) begin
            tail_q  <= push_data;
            state_q <= BufTwo;
          end else if (pop) begin
            state_q <= BufEmpty;
            valid_q <= 1'b0;
          end
        end
        BufTwo: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= push_data;
            else      state_q <= BufOne;
          end
        end
        default: begin
          state_q <= BufEmpty;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid = valid_q;
  assign data  = head_q;
  assign count = state_q;

endmodule

// File: rtl/asym_bram_fifo_ctrl.sv
// Narrow-write / wide-read FIFO controller around an external asymmetric BRAM.
// Optional feature macro: ASYM_FIFO_LEVEL_EN adds the level and almost_full ports.
module asym_bram_fifo_ctrl
  import asym_fifo_pkg::*;
#(
  parameter int unsigned WD_W      = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned WA_W      = 12,
  parameter int unsigned AF_THRESH = (2 ** WA_W) - 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [WD_W-1:0]                  s_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [WD_W*RATIO-1:0]            m_data,
  output logic                             wce,
  output logic [WA_W-1:0]                  wa,
  output logic [WD_W-1:0]                  wd,
  output logic                             rce,
  output logic [WA_W-log2_ratio(RATIO)-1:0] ra,
  input  logic [WD_W*RATIO-1:0]            rq
`ifdef ASYM_FIFO_LEVEL_EN
  ,
  output logic [WA_W:0]                    level,
  output logic                             almost_full
`endif
);

  localparam int unsigned DEPTH = 2 ** WA_W;
  localparam int unsigned RA_W  = ra_width(WA_W, RATIO);
  localparam int unsigned CW    = WA_W + 1;
  localparam int unsigned MD_W  = WD_W * RATIO;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] RatioC = CW'(RATIO);

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("RATIO must be a power of two >= 2");
  end
  if (AF_THRESH > DEPTH + 2 * RATIO) begin : g_bad_thresh
    $error("AF_THRESH exceeds the maximum reachable level");
  end

  logic [WA_W-1:0] wptr_q, wptr_d;
  logic [RA_W-1:0] rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rce_q;
  logic            accept, pop, buf_valid;
  logic [1:0]      buf_cnt, occ;

  // Ready only tracks words still resident in RAM: once a wide word is read
  // out its RAM slots are free, so the buffered words do not block writes.
  assign s_ready = rst_n & (cnt_q < DepthC);
  assign accept  = s_valid & s_ready;
  assign wce     = accept;
  assign wa      = wptr_q;
  assign wd      = s_data;

  assign m_valid = rst_n & buf_valid;
  assign pop     = m_valid & m_ready;

  // Wide words buffered plus the one possibly in flight from the RAM.
  assign occ = buf_cnt + {1'b0, rce_q};
  assign rce = rst_n & (cnt_q >= RatioC) & ({1'b0, occ} < (3'd2 + {2'b0, pop}));
  assign ra  = rptr_q;

  // Pointer and count next-state.
  always_comb begin
    wptr_d = wptr_q + WA_W'(accept);
    rptr_d = rptr_q + RA_W'(rce);
    cnt_d  = cnt_q + CW'(accept) - (rce ? RatioC : '0);
  end

  // Pointer, count and read-in-flight state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rce_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rce_q  <= rce;
    end
  end

  asym_fifo_outbuf #(
    .W(MD_W)
  ) u_outbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (rce_q),
    .push_data(rq),
    .pop      (pop),
    .valid    (buf_valid),
    .data     (m_data),
    .count    (buf_cnt)
  );

`ifdef ASYM_FIFO_LEVEL_EN
  localparam logic [CW-1:0] AfC = CW'(AF_THRESH);

  logic [1:0]    occ_d;
  logic [CW-1:0] total_d;

  assign occ_d   = occ - {1'b0, pop} + {1'b0, rce};
  assign total_d = cnt_d + RatioC * CW'(occ_d);

  // Level counts every narrow entry accepted but not yet consumed downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= total_d;
      almost_full <= (total_d >= AfC);
    end
  end
`endif

endmodule
